// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle control FSM
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // fetch marks the state where IRWrite/NextPC follow mem_ready
  typedef struct packed {
    logic       fetch;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_MEMADR: begin
        c.alu_src_b  = SRCB_IMM;
      end
      S_MEMRD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_RDATA;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_w      = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_b  = SRCB_REG;
        c.alu_op     = 1'b1;
      end
      S_EXECI: begin
        c.alu_src_b  = SRCB_IMM;
        c.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// rtl/mc_ctrl_fsm_alu_dec.sv - ALU operation and flag-write decode
module alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] Funct,
  input  logic       ALUOp,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       unused_imm;

  assign cmd        = Funct[4:1];
  assign s_bit      = Funct[0];
  assign unused_imm = Funct[5];

  // only add/sub produce meaningful carry and overflow
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (ALUOp) begin
      case (cmd)
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      FlagW[1] = s_bit;
      FlagW[0] = s_bit & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle processor main control FSM
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_eff;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:   state_d = S_MEMADR;
          OP_DP:    state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:    state_d = S_BRANCH;
          OP_UNDEF: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they change together with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // Reset must look like FETCH immediately, even while state_q is still mid-access
  assign ctrl_eff = reset ? state_ctrl(S_FETCH) : ctrl_q;

  assign IRWrite   = ctrl_eff.fetch & mem_ready & ~reset;
  assign NextPC    = ctrl_eff.fetch & mem_ready & ~reset;
  assign AdrSrc    = ctrl_eff.adr_src;
  assign ALUSrcA   = ctrl_eff.alu_src_a;
  assign ALUSrcB   = ctrl_eff.alu_src_b;
  assign ResultSrc = ctrl_eff.result_src;
  assign RegW      = ctrl_eff.reg_w;
  assign MemW      = ctrl_eff.mem_w;
  assign Branch    = ctrl_eff.branch;
  assign state     = state_q;

  alu_dec u_alu_dec (
    .Funct      (Funct),
    .ALUOp      (ctrl_eff.alu_op),
    .ALUControl (ALUControl),
    .FlagW      (FlagW)
  );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed scoreboard bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [3:0] state;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       chk_st;
    logic [3:0] st;
    logic [14:0] ctl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int regw_seen = 0;
  int memw_seen = 0;
  int br_seen = 0;

  logic [14:0] obs_ctl;
  assign obs_ctl = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    RegW, MemW, Branch, ALUControl, FlagW};

  function automatic logic [14:0] model(input logic [3:0] st, input logic rst,
                                        input logic mr, input logic [5:0] fn);
    logic irw, adr, sa, rw, mw, br, alu;
    logic [1:0] srcb, rs, ac, fw;
    logic [3:0] s, cmd;
    irw = 0; adr = 0; sa = 0; rw = 0; mw = 0; br = 0; alu = 0;
    srcb = 2'b00; rs = 2'b00; ac = 2'b00; fw = 2'b00;
    s = rst ? 4'd0 : st;
    case (s)
      4'd0: begin sa = 1; srcb = 2'b10; rs = 2'b10; irw = mr & ~rst; end
      4'd1: begin sa = 1; srcb = 2'b10; rs = 2'b10; end
      4'd2: srcb = 2'b01;
      4'd3: adr = 1;
      4'd4: begin rs = 2'b01; rw = 1; end
      4'd5: begin adr = 1; mw = 1; end
      4'd6: alu = 1;
      4'd7: begin srcb = 2'b01; alu = 1; end
      4'd8: rw = 1;
      4'd9: begin srcb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    if (alu) begin
      cmd = fn[4:1];
      case (cmd)
        4'b0100: ac = 2'b00;
        4'b0010: ac = 2'b01;
        4'b0000: ac = 2'b10;
        4'b1100: ac = 2'b11;
        default: ac = 2'b00;
      endcase
      fw = {fn[0], fn[0] & ((cmd == 4'b0100) || (cmd == 4'b0010))};
    end
    return {irw, irw, adr, sa, srcb, rs, rw, mw, br, ac, fw};
  endfunction

  task automatic step(input string tag, input logic r, input logic [1:0] op,
                      input logic [5:0] fn, input logic mr, input logic chk,
                      input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; Op = op; Funct = fn; mem_ready = mr;
    e.tag = tag; e.chk_st = chk; e.st = st; e.ctl = model(st, r, mr, fn);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk_st) begin
      checks++;
      assert (state === e.st) else begin
        errors++;
        $error("FAIL %s state got %0d want %0d", e.tag, state, e.st);
      end
    end
    checks++;
    assert (obs_ctl === e.ctl) else begin
      errors++;
      $error("FAIL %s ctrl got %h want %h", e.tag, obs_ctl, e.ctl);
    end
    if (RegW === 1'b1) regw_seen++;
    if (MemW === 1'b1) memw_seen++;
    if (Branch === 1'b1) br_seen++;
  endtask

  task automatic count_check(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s count got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    // reset for three cycles with memory ready
    step("rst0", 1, 2'b00, 6'b001001, 1, 1, 4'd0);
    step("rst1", 1, 2'b00, 6'b001001, 1, 1, 4'd0);
    step("rst2", 1, 2'b00, 6'b001001, 1, 1, 4'd0);

    regw_seen = 0;
    step("adds_f", 0, 2'b00, 6'b001001, 1, 1, 4'd0);
    step("adds_d", 0, 2'b00, 6'b001001, 1, 1, 4'd1);
    step("adds_x", 0, 2'b00, 6'b001001, 1, 1, 4'd6);
    step("adds_w", 0, 2'b00, 6'b001001, 1, 1, 4'd8);
    count_check("adds_regw", regw_seen, 1);

    step("subs_f", 0, 2'b00, 6'b000101, 1, 1, 4'd0);
    step("subs_d", 0, 2'b00, 6'b000101, 1, 1, 4'd1);
    step("subs_x", 0, 2'b00, 6'b000101, 1, 1, 4'd6);
    step("subs_w", 0, 2'b00, 6'b000101, 1, 1, 4'd8);

    step("orri_f", 0, 2'b00, 6'b111000, 1, 1, 4'd0);
    step("orri_d", 0, 2'b00, 6'b111000, 1, 1, 4'd1);
    step("orri_x", 0, 2'b00, 6'b111000, 1, 1, 4'd7);
    step("orri_w", 0, 2'b00, 6'b111000, 1, 1, 4'd8);

    step("ands_f", 0, 2'b00, 6'b000001, 1, 1, 4'd0);
    step("ands_d", 0, 2'b00, 6'b000001, 1, 1, 4'd1);
    step("ands_x", 0, 2'b00, 6'b000001, 1, 1, 4'd6);
    step("ands_w", 0, 2'b00, 6'b000001, 1, 1, 4'd8);

    step("oth_f", 0, 2'b00, 6'b010101, 1, 1, 4'd0);
    step("oth_d", 0, 2'b00, 6'b010101, 1, 1, 4'd1);
    step("oth_x", 0, 2'b00, 6'b010101, 1, 1, 4'd6);
    step("oth_w", 0, 2'b00, 6'b010101, 1, 1, 4'd8);

    regw_seen = 0;
    step("ldr_f",  0, 2'b01, 6'b011001, 1, 1, 4'd0);
    step("ldr_d",  0, 2'b01, 6'b011001, 1, 1, 4'd1);
    step("ldr_a",  0, 2'b01, 6'b011001, 1, 1, 4'd2);
    step("ldr_r0", 0, 2'b01, 6'b011001, 0, 1, 4'd3);
    step("ldr_r1", 0, 2'b01, 6'b011001, 0, 1, 4'd3);
    step("ldr_r2", 0, 2'b01, 6'b011001, 1, 1, 4'd3);
    step("ldr_wb", 0, 2'b01, 6'b011001, 1, 1, 4'd4);
    count_check("ldr_regw", regw_seen, 1);

    memw_seen = 0;
    step("str_f",  0, 2'b01, 6'b011000, 1, 1, 4'd0);
    step("str_d",  0, 2'b01, 6'b011000, 1, 1, 4'd1);
    step("str_a",  0, 2'b01, 6'b011000, 1, 1, 4'd2);
    step("str_w0", 0, 2'b01, 6'b011000, 0, 1, 4'd5);
    step("str_w1", 0, 2'b01, 6'b011000, 1, 1, 4'd5);
    count_check("str_memw", memw_seen, 2);

    br_seen = 0;
    step("b_stall", 0, 2'b10, 6'b000000, 0, 1, 4'd0);
    step("b_f",     0, 2'b10, 6'b000000, 1, 1, 4'd0);
    step("b_d",     0, 2'b10, 6'b000000, 1, 1, 4'd1);
    step("b_x",     0, 2'b10, 6'b000000, 1, 1, 4'd9);
    count_check("b_branch", br_seen, 1);

    step("und_f", 0, 2'b11, 6'b000000, 1, 1, 4'd0);
    step("und_d", 0, 2'b11, 6'b000000, 1, 1, 4'd1);

    regw_seen = 0;
    step("rl_f",   0, 2'b01, 6'b011001, 1, 1, 4'd0);
    step("rl_d",   0, 2'b01, 6'b011001, 1, 1, 4'd1);
    step("rl_a",   0, 2'b01, 6'b011001, 1, 1, 4'd2);
    step("rl_r0",  0, 2'b01, 6'b011001, 0, 1, 4'd3);
    step("rl_rst", 1, 2'b01, 6'b011001, 0, 0, 4'd3);
    step("rl_f2",  0, 2'b01, 6'b011001, 1, 1, 4'd0);
    step("rl_d2",  1, 2'b01, 6'b011001, 1, 1, 4'd1);
    step("rl_f3",  0, 2'b01, 6'b011001, 0, 1, 4'd0);
    count_check("rl_regw", regw_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
